// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM encoding, bus direction codes and
// the store-watch match pair.
package dmem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [15:0] WATCH_ADDR = 16'd0;
    localparam logic [15:0] WATCH_DATA = 16'd4;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/dmem_if.sv
// CPU data-bus control/status bundle. The bidirectional data lines travel as a plain inout
// beside this interface so the tristate stays on a module port.
interface dmem_if;

    logic [15:0] da;
    logic        rw;
    logic        ready;
    logic        err;
    logic        watch_hit;

    modport master (
        output da,
        output rw,
        input  ready,
        input  err,
        input  watch_hit
    );

    modport slave (
        input  da,
        input  rw,
        output ready,
        output err,
        output watch_hit
    );

endinterface

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer: holds the last accepted store, flags a forward hit for
// reads of the same index, and strobes the commit of the old entry when a new one lands.
module dmem_wbuf #(
    parameter int unsigned AW    = 7,
    parameter int unsigned WIDTH = 16
) (
    input  logic             ck_i,
    input  logic             rst_i,
    input  logic             cap_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [AW-1:0]    addr_o,
    output logic [WIDTH-1:0] data_o,
    output logic             fwd_o,
    output logic             commit_o
);

    logic             valid_q;
    logic [AW-1:0]    addr_q;
    logic [WIDTH-1:0] data_q;

    // Reset drops a pending entry without committing it.
    always_ff @(negedge ck_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (cap_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end
    end

    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign fwd_o    = valid_q && (addr_q == addr_i);
    assign commit_o = cap_i && valid_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory end of the CPU load/store bus: clear walk after reset, posted writes with read
// forwarding, sticky range error. Define DMEM_WATCH_EN to add the store-watch comparator.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7,
    parameter int unsigned WIDTH = 16
) (
    input  logic             ck,
    input  logic             rst,
    dmem_if.slave            bus,
    inout  wire  [WIDTH-1:0] dd
);

    localparam logic [15:0]   DEPTH_W  = 16'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_e           state_q, state_d;
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             err_q, err_d;

    logic             in_range, rd_req, wr_req;
    logic [AW-1:0]    idx;
    logic             wb_cap, wb_fwd, wb_commit;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign idx      = bus.da[AW-1:0];
    assign in_range = bus.da < DEPTH_W;
    assign rd_req   = bus.rw == RW_READ;
    assign wr_req   = bus.rw == RW_WRITE;
    assign wb_cap   = !rst && (state_q == ST_RUN) && wr_req && in_range;

    dmem_wbuf #(
        .AW    (AW),
        .WIDTH (WIDTH)
    ) u_wbuf (
        .ck_i     (ck),
        .rst_i    (rst),
        .cap_i    (wb_cap),
        .addr_i   (idx),
        .data_i   (dd),
        .addr_o   (wb_addr),
        .data_o   (wb_data),
        .fwd_o    (wb_fwd),
        .commit_o (wb_commit)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        rd_d      = rd_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        unique case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_IDX) state_d = ST_RUN;
                if (rd_req) rd_d = '0;
                else        err_d = 1'b1;
            end
            ST_RUN: begin
                if (!in_range) begin
                    err_d = 1'b1;
                    if (rd_req) rd_d = '0;
                end else if (rd_req) begin
                    rd_d = wb_fwd ? wb_data : mem[idx];
                end else begin
                    // Retire the previous store to make room for the one being captured.
                    mem_we    = wb_commit;
                    mem_waddr = wb_addr;
                    mem_wdata = wb_data;
                end
            end
        endcase
    end

    always_ff @(negedge ck) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_ptr_q <= '0;
            rd_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            rd_q      <= rd_d;
            err_q     <= err_d;
        end
    end

    always_ff @(negedge ck) begin
        if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign dd        = rd_req ? rd_q : 'z;
    assign bus.ready = state_q == ST_RUN;
    assign bus.err   = err_q;

`ifdef DMEM_WATCH_EN
    logic watch_q;

    always_ff @(negedge ck) begin
        if (rst) begin
            watch_q <= 1'b0;
        end else if (wb_cap && (bus.da == WATCH_ADDR) && (dd == WATCH_DATA)) begin
            watch_q <= 1'b1;
        end
    end

    assign bus.watch_hit = watch_q;
`else
    assign bus.watch_hit = 1'b0;
`endif

endmodule
